// File: rtl/ftdi_fifo_avalon_st_instream.sv
// FTDI FIFO read-side bridge: pulls bytes with a timed RD_n strobe and presents them as Avalon-ST beats.
// Optional macro FTDI_RXF_SYNC_EN adds a two-flop synchronizer on iFIFO_RXF_n.
module ftdi_fifo_avalon_st_instream #(
  parameter int unsigned RD_PULSE_CYCLES  = 4,
  parameter int unsigned PRECHARGE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iFIFO_RXF_n,
  output logic       oFIFO_RD_n,
  input  logic [7:0] iFIFO_DATA,
  output logic       oFIFO_OE_n,
  output logic       oST_VALID,
  input  logic       iST_READY,
  output logic [7:0] oST_DATA
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_RXF   = 3'd1,
    ST_RD_PULSE   = 3'd2,
    ST_PRECHARGE  = 3'd3,
    ST_HOLD_VALID = 3'd4
  } state_t;

  // Counters are loaded with N-1 so that the state lasts exactly N cycles.
  localparam logic [3:0] PULSE_LOAD = 4'(RD_PULSE_CYCLES - 1);
  localparam logic [3:0] PRE_LOAD   = 4'(PRECHARGE_CYCLES - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       rd_n_q;
  logic       valid_q;
  logic [7:0] data_q;
  logic       rxf_n_s;
  logic       handshake_s;

`ifdef FTDI_RXF_SYNC_EN
  logic rxf_meta_q;
  logic rxf_sync_q;

  // Two-flop synchronizer; idles at 1 so reset never looks like a non-empty FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxf_meta_q <= 1'b1;
      rxf_sync_q <= 1'b1;
    end else begin
      rxf_meta_q <= iFIFO_RXF_n;
      rxf_sync_q <= rxf_meta_q;
    end
  end

  assign rxf_n_s = rxf_sync_q;
`else
  assign rxf_n_s = iFIFO_RXF_n;
`endif

  assign handshake_s = valid_q & iST_READY;

  // Read-sequencing FSM with its counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rd_n_q  <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      if (handshake_s) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          rd_n_q  <= 1'b1;
          valid_q <= 1'b0;
          state_q <= ST_WAIT_RXF;
        end
        ST_WAIT_RXF: begin
          if (!rxf_n_s) begin
            rd_n_q  <= 1'b0;
            cnt_q   <= PULSE_LOAD;
            state_q <= ST_RD_PULSE;
          end
        end
        ST_RD_PULSE: begin
          if (cnt_q == 4'd0) begin
            rd_n_q  <= 1'b1;
            data_q  <= iFIFO_DATA;
            valid_q <= 1'b1;
            cnt_q   <= PRE_LOAD;
            state_q <= ST_PRECHARGE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_PRECHARGE: begin
          // A handshake on the expiry edge itself also counts as a finished beat.
          if (cnt_q == 4'd0) begin
            if (valid_q && !handshake_s) begin
              state_q <= ST_HOLD_VALID;
            end else begin
              state_q <= ST_WAIT_RXF;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_HOLD_VALID: begin
          rd_n_q <= 1'b1;
          if (handshake_s) begin
            state_q <= ST_WAIT_RXF;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 4'd0;
          rd_n_q  <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign oFIFO_RD_n = rd_n_q;
  assign oFIFO_OE_n = 1'b1;
  assign oST_VALID  = valid_q;
  assign oST_DATA   = data_q;

endmodule

// File: tb/tb_ftdi_fifo_avalon_st_instream.sv
// Self-checking bench: reset checks, single-byte vector table, hand-written corner sequences,
// and a randomized run scored against an FTDI FIFO / Avalon-ST byte-stream model.
module tb_ftdi_fifo_avalon_st_instream;

  localparam int RD_PULSE  = 4;
  localparam int PRECHARGE = 3;
  localparam int BYTE_PERIOD = RD_PULSE + PRECHARGE + 1;
`ifdef FTDI_RXF_SYNC_EN
  localparam int SYNC_LAT = 3;
`else
  localparam int SYNC_LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic       iFIFO_RXF_n;
  logic       oFIFO_RD_n;
  logic [7:0] iFIFO_DATA;
  logic       oFIFO_OE_n;
  logic       oST_VALID;
  logic       iST_READY;
  logic [7:0] oST_DATA;

  ftdi_fifo_avalon_st_instream #(
    .RD_PULSE_CYCLES (RD_PULSE),
    .PRECHARGE_CYCLES(PRECHARGE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .iFIFO_RXF_n(iFIFO_RXF_n),
    .oFIFO_RD_n (oFIFO_RD_n),
    .iFIFO_DATA (iFIFO_DATA),
    .oFIFO_OE_n (oFIFO_OE_n),
    .oST_VALID  (oST_VALID),
    .iST_READY  (iST_READY),
    .oST_DATA   (oST_DATA)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] data;
    int         ready_low;
    int         exp_lat;
    int         exp_rd_low;
    int         exp_vcyc;
    logic [7:0] exp_data;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_beats = 0;
  bit model_en = 1'b0;
  logic rd_prev = 1'b1;
  logic valid_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  int low_len = 0;
  int high_len = 100;
  logic [7:0] ftdi_q[$];
  logic [7:0] exp_q[$];
  int fall_cycles[$];

  int lat, lowc, vcyc, k, t, b0, pushed;
  bit ok;

  task automatic chk(input bit good, input string name, input int act, input int req);
    n_checks++;
    if (!good) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // FTDI side: RXF_n reflects FIFO occupancy, data bus shows the head byte.
  function automatic void drive_ftdi();
    iFIFO_RXF_n = (ftdi_q.size() == 0);
    iFIFO_DATA  = (ftdi_q.size() != 0) ? ftdi_q[0] : 8'h00;
  endfunction

  task automatic monitor(input logic rdy);
    logic [7:0] want;
    if (valid_prev && rdy) begin
      n_beats++;
      chk(exp_q.size() != 0, "beat_without_byte", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk(data_prev == want, "beat_data", int'(data_prev), int'(want));
      end
      chk(oST_VALID == 1'b0, "valid_drop", int'(oST_VALID), 0);
    end else if (valid_prev) begin
      chk(oST_VALID == 1'b1 && oST_DATA == data_prev, "hold_stable", int'(oST_DATA), int'(data_prev));
    end
    if (rd_prev && !oFIFO_RD_n) begin
      chk(exp_q.size() == 0 && !oST_VALID, "read_while_pending", exp_q.size(), 0);
      chk(high_len >= PRECHARGE + 1, "precharge_len", high_len, PRECHARGE + 1);
      fall_cycles.push_back(cyc);
      low_len = 1;
    end else if (!rd_prev && oFIFO_RD_n) begin
      chk(low_len == RD_PULSE, "pulse_len", low_len, RD_PULSE);
      chk(oST_VALID == 1'b1, "valid_rise", int'(oST_VALID), 1);
      high_len = 1;
      chk(ftdi_q.size() != 0, "read_from_empty", ftdi_q.size(), 1);
      if (ftdi_q.size() != 0) exp_q.push_back(ftdi_q.pop_front());
    end else if (!oFIFO_RD_n) begin
      low_len++;
    end else begin
      high_len++;
    end
    chk(oFIFO_OE_n == 1'b1, "oe_n", int'(oFIFO_OE_n), 1);
  endtask

  task automatic tick();
    logic rdy;
    rdy = iST_READY;
    @(posedge clk);
    #1;
    cyc++;
    if (model_en) monitor(rdy);
    rd_prev    = oFIFO_RD_n;
    valid_prev = oST_VALID;
    data_prev  = oST_DATA;
    if (model_en) drive_ftdi();
  endtask

  task automatic apply_reset();
    model_en = 1'b0;
    rst = 1'b0;
    iFIFO_RXF_n = 1'b1;
    iST_READY = 1'b0;
    iFIFO_DATA = 8'h00;
    ftdi_q.delete();
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b1;
    low_len = 0;
    high_len = 100;
    repeat (2) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'hA5, 0,  SYNC_LAT, RD_PULSE, 1,  8'hA5};
    vecs[1] = '{8'h3C, 1,  SYNC_LAT, RD_PULSE, 2,  8'h3C};
    vecs[2] = '{8'h96, 2,  SYNC_LAT, RD_PULSE, 3,  8'h96};
    vecs[3] = '{8'h0F, 3,  SYNC_LAT, RD_PULSE, 4,  8'h0F};
    vecs[4] = '{8'hF0, 10, SYNC_LAT, RD_PULSE, 11, 8'hF0};
    vecs[5] = '{8'h00, 5,  SYNC_LAT, RD_PULSE, 6,  8'h00};

    // Reset with arbitrary inputs.
    rst = 1'b0;
    iFIFO_RXF_n = 1'b0;
    iST_READY = 1'b1;
    iFIFO_DATA = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      iFIFO_RXF_n = 1'($urandom);
      iST_READY   = 1'($urandom);
      iFIFO_DATA  = 8'($urandom);
      tick();
      chk(oFIFO_RD_n == 1'b1 && oFIFO_OE_n == 1'b1 && oST_VALID == 1'b0 && oST_DATA == 8'h00,
          "reset_outputs", int'({oFIFO_RD_n, oFIFO_OE_n, oST_VALID, oST_DATA}), int'(11'h600));
    end

    // Single-byte vectors.
    apply_reset();
    for (int i = 0; i < NV; i++) begin
      iFIFO_DATA  = vecs[i].data;
      iFIFO_RXF_n = 1'b0;
      iST_READY   = 1'($urandom);
      lat = 0;
      do begin
        tick();
        lat++;
      end while (oFIFO_RD_n == 1'b1 && lat < 20);
      chk(lat == vecs[i].exp_lat, "rxf_to_rd_latency", lat, vecs[i].exp_lat);
      iFIFO_RXF_n = 1'b1;
      lowc = 1;
      for (int j = 0; j < 20; j++) begin
        tick();
        if (oFIFO_RD_n == 1'b0) lowc++;
        else break;
      end
      chk(lowc == vecs[i].exp_rd_low, "rd_low_cycles", lowc, vecs[i].exp_rd_low);
      chk(oST_VALID == 1'b1 && oST_DATA == vecs[i].exp_data, "first_beat_data",
          int'(oST_DATA), int'(vecs[i].exp_data));
      iFIFO_DATA = ~vecs[i].data;
      vcyc = 1;
      ok = 1'b1;
      k = 0;
      iST_READY = (vecs[i].ready_low == 0);
      for (int j = 0; j < 40; j++) begin
        tick();
        k++;
        if (oST_VALID) begin
          vcyc++;
          if (oST_DATA != vecs[i].exp_data || oFIFO_RD_n != 1'b1) ok = 1'b0;
          iST_READY = (k >= vecs[i].ready_low);
        end else begin
          break;
        end
      end
      chk(vcyc == vecs[i].exp_vcyc, "valid_cycles", vcyc, vecs[i].exp_vcyc);
      chk(ok, "valid_hold_stable", int'(ok), 1);
      iST_READY = 1'b0;
      repeat (6) tick();
    end

    // Burst of three bytes with READY high.
    apply_reset();
    fall_cycles.delete();
    model_en = 1'b1;
    ftdi_q = '{8'h01, 8'h02, 8'h03};
    drive_ftdi();
    iST_READY = 1'b1;
    b0 = n_beats;
    t = 0;
    while (n_beats - b0 < 3 && t < 100) begin
      tick();
      t++;
    end
    chk(n_beats - b0 == 3, "burst_beats", n_beats - b0, 3);
    chk(fall_cycles.size() == 3, "burst_reads", fall_cycles.size(), 3);
    if (fall_cycles.size() >= 3) begin
      chk(fall_cycles[1] - fall_cycles[0] == BYTE_PERIOD, "burst_spacing_1",
          fall_cycles[1] - fall_cycles[0], BYTE_PERIOD);
      chk(fall_cycles[2] - fall_cycles[1] == BYTE_PERIOD, "burst_spacing_2",
          fall_cycles[2] - fall_cycles[1], BYTE_PERIOD);
    end

    // Backpressure with RXF_n held low.
    apply_reset();
    model_en = 1'b1;
    ftdi_q = '{8'h5A, 8'h77};
    drive_ftdi();
    iST_READY = 1'b0;
    t = 0;
    while (!oST_VALID && t < 50) begin
      tick();
      t++;
    end
    chk(oST_VALID == 1'b1, "bp_valid", int'(oST_VALID), 1);
    ok = 1'b1;
    repeat (12) begin
      tick();
      if (oST_VALID != 1'b1 || oST_DATA != 8'h5A || oFIFO_RD_n != 1'b1) ok = 1'b0;
    end
    chk(ok, "bp_hold", int'(oST_DATA), 8'h5A);
    iST_READY = 1'b1;
    t = 0;
    do begin
      tick();
      t++;
    end while (oFIFO_RD_n == 1'b1 && t < 20);
    chk(t == 2, "bp_restart_delay", t, 2);
    t = 0;
    while ((ftdi_q.size() != 0 || exp_q.size() != 0 || oST_VALID) && t < 60) begin
      tick();
      t++;
    end
    chk(ftdi_q.size() == 0 && exp_q.size() == 0, "bp_drain", exp_q.size(), 0);

    // Reset on the second cycle of the RD_n pulse.
    apply_reset();
    model_en = 1'b1;
    ftdi_q = '{8'hC3};
    drive_ftdi();
    iST_READY = 1'b1;
    t = 0;
    while (oFIFO_RD_n == 1'b1 && t < 20) begin
      tick();
      t++;
    end
    tick();
    chk(oFIFO_RD_n == 1'b0, "midread_in_pulse", int'(oFIFO_RD_n), 0);
    model_en = 1'b0;
    rst = 1'b0;
    #1;
    chk(oFIFO_RD_n == 1'b1 && oST_VALID == 1'b0, "midread_rd_release",
        int'({oFIFO_RD_n, oST_VALID}), 2);
    apply_reset();
    iST_READY = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      tick();
      if (oST_VALID != 1'b0 || oFIFO_RD_n != 1'b1) ok = 1'b0;
    end
    chk(ok, "midread_no_beat", int'(oST_VALID), 0);
    model_en = 1'b1;
    ftdi_q = '{8'h3C};
    drive_ftdi();
    b0 = n_beats;
    t = 0;
    while (n_beats == b0 && t < 60) begin
      tick();
      t++;
    end
    chk(n_beats - b0 == 1, "midread_fresh_read", n_beats - b0, 1);

    // Randomized traffic against the byte-stream model.
    apply_reset();
    model_en = 1'b1;
    b0 = n_beats;
    pushed = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        ftdi_q.push_back(8'($urandom));
        pushed++;
        drive_ftdi();
      end
      iST_READY = ($urandom_range(0, 3) != 0);
      tick();
    end
    iST_READY = 1'b1;
    t = 0;
    while ((ftdi_q.size() != 0 || exp_q.size() != 0 || oST_VALID) && t < 2000) begin
      tick();
      t++;
    end
    chk(ftdi_q.size() == 0 && exp_q.size() == 0, "random_drain", ftdi_q.size() + exp_q.size(), 0);
    chk(n_beats - b0 == pushed, "random_beat_count", n_beats - b0, pushed);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
